lpc_host_sched: RTL and testbench

Host-side LPC cycle scheduler. It shares one LPC bus between two requesters, such as a debug bridge and a POST-code forwarder. It arbitrates round-robin, then sequences complete I/O Read / I/O Write cycles on LFRAME#/LAD toward lpc_periph-compatible targets. It handles SYNC wait states, SYNC error and no-response timeout with abort.

---
 rtl/lpc_host_sched.sv | 201 ++++++++++++++++++++
 tb/tb_lpc_host_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host_sched.sv
// Host-side LPC I/O cycle scheduler: round-robin between two requesters, then
// drives START/CYCTYPE/ADDR/DATA/TAR/SYNC with wait, error and timeout handling.
module lpc_host_sched #(
  parameter int unsigned SYNC_TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  input  logic [3:0]  lad_i
);

  // One counter serves both the SYNC timeout and the 4-clock abort frame.
  localparam int unsigned CNT_MAX = (SYNC_TIMEOUT > 4) ? SYNC_TIMEOUT : 4;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [4:0] {
    IDLE, START, CYCTYPE, ADDR1, ADDR2, ADDR3, ADDR4, DATA_W1, DATA_W2,
    TAR1, TAR2, SYNC, DATA_R1, DATA_R2, FTAR1, FTAR2, ABORT, ABORT_END, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rbuf_q, rbuf_d;
  logic             errf_q, errf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       done_d;
  logic             err_d;
  logic [7:0]       rdata_d;
  logic             busy_d;
  logic             lframe_d;
  logic [3:0]       lad_d;
  logic             lad_oe_d;
  logic             sel;

  // State, latched request and registered bus outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      errf_q   <= 1'b0;
      cnt_q    <= '0;
      done_o   <= '0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      busy_o   <= 1'b0;
      lframe_o <= 1'b1;
      lad_o    <= 4'hF;
      lad_oe_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      errf_q   <= errf_d;
      cnt_q    <= cnt_d;
      done_o   <= done_d;
      err_o    <= err_d;
      rdata_o  <= rdata_d;
      busy_o   <= busy_d;
      lframe_o <= lframe_d;
      lad_o    <= lad_d;
      lad_oe_o <= lad_oe_d;
    end
  end

  // Next state, then the outputs that belong to the state being entered.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    errf_d   = errf_q;
    cnt_d    = cnt_q;
    done_d   = 2'b00;
    err_d    = 1'b0;
    rdata_d  = rdata_o;
    lframe_d = 1'b1;
    lad_d    = 4'hF;
    lad_oe_d = 1'b0;
    sel      = (req_i == 2'b11) ? ~last_q : req_i[1];

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = START;
          gnt_d   = sel;
          last_d  = sel;
          we_d    = we_i[sel];
          addr_d  = sel ? addr_i[31:16] : addr_i[15:0];
          wdata_d = sel ? wdata_i[15:8] : wdata_i[7:0];
          errf_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      START:     state_d = CYCTYPE;
      CYCTYPE:   state_d = ADDR1;
      ADDR1:     state_d = ADDR2;
      ADDR2:     state_d = ADDR3;
      ADDR3:     state_d = ADDR4;
      ADDR4:     state_d = we_q ? DATA_W1 : TAR1;
      DATA_W1:   state_d = DATA_W2;
      DATA_W2:   state_d = TAR1;
      TAR1:      state_d = TAR2;
      TAR2:      state_d = SYNC;
      SYNC: begin
        if (lad_i == 4'h0) begin
          state_d = we_q ? FTAR1 : DATA_R1;
        end else if (lad_i == 4'hA) begin
          errf_d  = 1'b1;
          state_d = FTAR1;
        end else if (cnt_q == CNT_W'(SYNC_TIMEOUT - 1)) begin
          errf_d  = 1'b1;
          cnt_d   = '0;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA_R1: begin
        rbuf_d[3:0] = lad_i;
        state_d     = DATA_R2;
      end
      DATA_R2: begin
        rbuf_d[7:4] = lad_i;
        state_d     = FTAR1;
      end
      FTAR1:     state_d = FTAR2;
      FTAR2:     state_d = DONE;
      ABORT: begin
        if (cnt_q == CNT_W'(3)) begin
          state_d = ABORT_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ABORT_END: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    case (state_d)
      START: begin
        lframe_d = 1'b0;
        lad_d    = 4'h0;
        lad_oe_d = 1'b1;
      end
      CYCTYPE: begin
        lad_d    = {2'b00, we_q, 1'b0};
        lad_oe_d = 1'b1;
      end
      ADDR1:   begin lad_d = addr_q[15:12]; lad_oe_d = 1'b1; end
      ADDR2:   begin lad_d = addr_q[11:8];  lad_oe_d = 1'b1; end
      ADDR3:   begin lad_d = addr_q[7:4];   lad_oe_d = 1'b1; end
      ADDR4:   begin lad_d = addr_q[3:0];   lad_oe_d = 1'b1; end
      DATA_W1: begin lad_d = wdata_q[3:0];  lad_oe_d = 1'b1; end
      DATA_W2: begin lad_d = wdata_q[7:4];  lad_oe_d = 1'b1; end
      TAR1:    lad_oe_d = 1'b1;
      ABORT: begin
        lframe_d = 1'b0;
        lad_oe_d = 1'b1;
      end
      DONE: begin
        done_d = gnt_q ? 2'b10 : 2'b01;
        err_d  = errf_q;
        if (!we_q && !errf_q) begin
          rdata_d = rbuf_q;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_lpc_host_sched.sv
// Self-checking bench for lpc_host_sched: directed table, arbitration and reset
// sequences, then random transactions against a transaction-level LPC model.
module tb_lpc_host_sched;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        nrst_i = 1'b0;
  logic [1:0]  req_i = '0;
  logic [1:0]  we_i = '0;
  logic [31:0] addr_i = '0;
  logic [15:0] wdata_i = '0;
  logic [3:0]  lad_i = 4'hF;
  logic [1:0]  done_o;
  logic        err_o;
  logic [7:0]  rdata_o;
  logic        busy_o;
  logic        lframe_o;
  logic [3:0]  lad_o;
  logic        lad_oe_o;

  lpc_host_sched #(.SYNC_TIMEOUT(TO)) dut (
    .clk_i(clk), .nrst_i(nrst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .lframe_o(lframe_o), .lad_o(lad_o), .lad_oe_o(lad_oe_o),
    .lad_i(lad_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [63:0] sync;
    int          nsync;
    logic [7:0]  data;
    int          lat;
    logic [1:0]  gdone;
    logic        err;
    logic [7:0]  rdata;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;

  // Transaction model: expected per-clock bus trace and what the target drives.
  logic       q_lf[$];
  logic       q_oe[$];
  logic [3:0] q_lad[$];
  logic [3:0] q_lin[$];
  logic       last_m = 1'b1;
  logic [7:0] rdata_m = '0;
  logic [1:0] done_m;
  logic       err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic lf, input logic [3:0] lad, input logic oe,
                               input logic [3:0] lin);
    q_lf.push_back(lf);
    q_lad.push_back(lad);
    q_oe.push_back(oe);
    q_lin.push_back(lin);
  endfunction

  function automatic void build(input logic [1:0] mask, input logic [1:0] we,
                                input logic [31:0] addr, input logic [15:0] wdata,
                                input logic [63:0] sync, input int nsync,
                                input logic [7:0] data);
    logic g, w;
    logic [15:0] a;
    logic [7:0] wd;
    logic [3:0] code;
    int cnt, k, outcome;
    q_lf.delete(); q_lad.delete(); q_oe.delete(); q_lin.delete();
    g = (mask == 2'b11) ? !last_m : mask[1];
    last_m = g;
    w  = we[g];
    a  = g ? addr[31:16] : addr[15:0];
    wd = g ? wdata[15:8] : wdata[7:0];
    push(1'b0, 4'h0, 1'b1, 4'hF);
    push(1'b1, w ? 4'h2 : 4'h0, 1'b1, 4'hF);
    for (int i = 0; i < 4; i++) push(1'b1, a[15-4*i -: 4], 1'b1, 4'hF);
    if (w) begin
      push(1'b1, wd[3:0], 1'b1, 4'hF);
      push(1'b1, wd[7:4], 1'b1, 4'hF);
    end
    push(1'b1, 4'hF, 1'b1, 4'hF);
    push(1'b1, 4'hF, 1'b0, 4'hF);
    cnt = 0; k = 0; outcome = 0;
    forever begin
      code = (k < nsync) ? sync[4*k +: 4] : 4'hF;
      push(1'b1, 4'hF, 1'b0, code);
      k++;
      if (code == 4'h0) begin outcome = 0; break; end
      if (code == 4'hA) begin outcome = 1; break; end
      cnt++;
      if (cnt == int'(TO)) begin outcome = 2; break; end
    end
    if (outcome == 0 && !w) begin
      push(1'b1, 4'hF, 1'b0, data[3:0]);
      push(1'b1, 4'hF, 1'b0, data[7:4]);
    end
    if (outcome == 2) begin
      for (int i = 0; i < 4; i++) push(1'b0, 4'hF, 1'b1, 4'hF);
      push(1'b1, 4'hF, 1'b0, 4'hF);
    end else begin
      push(1'b1, 4'hF, 1'b0, 4'hF);
      push(1'b1, 4'hF, 1'b0, 4'hF);
    end
    push(1'b1, 4'hF, 1'b0, 4'hF);
    done_m = g ? 2'b10 : 2'b01;
    err_m  = (outcome != 0);
    if (outcome == 0 && !w) rdata_m = data;
  endfunction

  // Drive one transaction from an IDLE clock; returns at the following IDLE clock.
  task automatic run_txn(input string name, input logic [1:0] mask, input logic [1:0] we,
                         input logic [31:0] addr, input logic [15:0] wdata,
                         input logic [63:0] sync, input int nsync, input logic [7:0] data,
                         input logic hold, output int done_at, output logic [1:0] dmask);
    logic [17:0] act, exp;
    int n;
    build(mask, we, addr, wdata, sync, nsync, data);
    req_i = mask; we_i = we; addr_i = addr; wdata_i = wdata; lad_i = 4'hF;
    done_at = -1; dmask = '0;
    n = q_lf.size();
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      lad_i = q_lin[k];
      if (done_o != 2'b00 && done_at < 0) begin
        done_at = k;
        dmask = done_o;
      end
      act = {lframe_o, lad_oe_o, q_oe[k] ? lad_o : 4'h0, done_o, busy_o,
             (k == n-1) ? err_o : 1'b0, (k == n-1) ? rdata_o : 8'h00};
      exp = {q_lf[k], q_oe[k], q_oe[k] ? q_lad[k] : 4'h0,
             (k == n-1) ? done_m : 2'b00, 1'b1,
             (k == n-1) ? err_m : 1'b0, (k == n-1) ? rdata_m : 8'h00};
      check($sformatf("%s clk%0d", name, k), 32'(act), 32'(exp));
    end
    if (!hold) req_i = '0;
    @(negedge clk);
    lad_i = 4'hF;
    check({name, " idle"}, {29'd0, busy_o, done_o}, 32'd0);
  endtask

  vec_t tbl [6];
  logic [3:0] codes [8];

  initial begin
    int dat;
    logic [1:0] dm;
    logic [63:0] s;

    tbl[0] = '{2'b01, 2'b01, 32'h0000_0080, 16'h00A5, 64'h0,         1, 8'h00, 13, 2'b01, 1'b0, 8'h00};
    tbl[1] = '{2'b10, 2'b00, 32'h03F8_0000, 16'h0000, 64'h0555,      4, 8'h3C, 16, 2'b10, 1'b0, 8'h3C};
    tbl[2] = '{2'b01, 2'b00, 32'h0000_0060, 16'h0000, 64'h0,         0, 8'h77, 21, 2'b01, 1'b1, 8'h3C};
    tbl[3] = '{2'b10, 2'b10, 32'h0080_0000, 16'h5A00, 64'hA,         1, 8'h00, 13, 2'b10, 1'b1, 8'h3C};
    tbl[4] = '{2'b01, 2'b00, 32'h0000_1234, 16'h0000, 64'h066,       3, 8'h5A, 15, 2'b01, 1'b0, 8'h5A};
    tbl[5] = '{2'b10, 2'b00, 32'hABCD_0000, 16'h0000, 64'h5555_5555, 8, 8'h99, 21, 2'b10, 1'b1, 8'h5A};
    codes = '{4'h5, 4'h6, 4'h5, 4'h0, 4'hF, 4'h3, 4'hA, 4'h0};

    repeat (3) @(negedge clk);
    check("reset state", {21'd0, lframe_o, lad_o, lad_oe_o, done_o, err_o, busy_o, |rdata_o},
          {21'd0, 1'b1, 4'hF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
    nrst_i = 1'b1;
    @(negedge clk);

    // Directed table with hand-derived latency, grant, error and read data.
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].sync, tbl[i].nsync, tbl[i].data, 1'b0, dat, dm);
      check($sformatf("tbl%0d latency", i), 32'(dat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d grant", i), 32'(dm), 32'(tbl[i].gdone));
      check($sformatf("tbl%0d err/rdata", i), {23'd0, err_m, rdata_o}, {23'd0, tbl[i].err, tbl[i].rdata});
    end

    // Reset in ADDR2 of a read with the request held; restart from a fresh START.
    req_i = 2'b01; we_i = 2'b00; addr_i = 32'h0000_2E2E;
    @(posedge clk);
    repeat (4) @(negedge clk);
    nrst_i = 1'b0;
    #1;
    check("async reset", {29'd0, lframe_o, lad_oe_o, busy_o}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    nrst_i = 1'b1;
    last_m = 1'b1;
    rdata_m = '0;
    run_txn("post-reset", 2'b01, 2'b00, 32'h0000_2E2E, 16'h0, 64'h0, 1, 8'hC3, 1'b0, dat, dm);
    check("post-reset latency", 32'(dat), 32'd13);

    // Both requests from reset, held throughout: strict alternation 0,1,0,1.
    nrst_i = 1'b0;
    @(negedge clk);
    nrst_i = 1'b1;
    last_m = 1'b1;
    rdata_m = '0;
    for (int i = 0; i < 4; i++) begin
      run_txn($sformatf("alt%0d", i), 2'b11, 2'b01, 32'h0070_0080, 16'h1122, 64'h0, 1,
              8'h00, 1'b1, dat, dm);
      check($sformatf("alt%0d grant", i), 32'(dm), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_i = '0;
    @(negedge clk);

    // Random transactions against the model.
    for (int t = 0; t < 40; t++) begin
      s = '0;
      for (int j = 0; j < 16; j++) s[4*j +: 4] = codes[$urandom_range(0, 7)];
      run_txn($sformatf("rnd%0d", t), 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
              $urandom, 16'($urandom), s, int'($urandom_range(0, 10)), 8'($urandom),
              1'b0, dat, dm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
